// File: rtl/badge_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | badge_uart_pkg                                                       |
// | Command letters, reset mask and FSM encodings of the cat protocol.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package badge_uart_pkg;

  localparam int NUM_CATS = 8;

  localparam logic [7:0] CMD_OFF_BASE   = 8'h41;
  localparam logic [7:0] CMD_ON_BASE    = 8'h61;
  localparam logic [7:0] CAT_RESET_MASK = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  function automatic logic [7:0] cmd_byte(input logic on, input logic [2:0] idx);
    return (on ? CMD_ON_BASE : CMD_OFF_BASE) + {5'd0, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cat_cmd_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cat_cmd_tx_if                                                        |
// | Request/status bundle between a controller and cat_cmd_tx.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cat_cmd_tx_if;
  import badge_uart_pkg::*;

  logic [NUM_CATS-1:0] target;
  logic                update;
  logic                force_all;
  logic                tx;
  logic                busy;
  logic                done;
  logic [NUM_CATS-1:0] shadow;

  modport master (output target, update, force_all,
                  input  tx, busy, done, shadow);
  modport slave  (input  target, update, force_all,
                  output tx, busy, done, shadow);
endinterface
`default_nettype wire

// File: rtl/cat_cmd_tx_uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_byte                                                         |
// | 8N1 serialiser; start pulses while a frame is in flight are ignored. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       start,
  input  wire logic [7:0] data,
  output logic            tx,
  output logic            busy,
  output logic            done
);
  localparam int              c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

  logic [c_baud_w-1:0] r_baud;
  logic [3:0]          r_bit;
  logic [8:0]          r_shift;
  logic                r_tx;
  logic                r_busy;
  logic                w_bit_end;

  assign w_bit_end = (r_baud == c_baud_last);

  // r_bit 0 is the start bit, 1..8 data, 9 the stop bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
    end else if (!r_busy) begin
      if (start) begin
        r_busy  <= 1'b1;
        r_tx    <= 1'b0;
        r_shift <= {1'b1, data};
        r_baud  <= '0;
        r_bit   <= '0;
      end
    end else if (w_bit_end) begin
      r_baud <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_busy && w_bit_end && (r_bit == 4'd9);
endmodule
`default_nettype wire

// File: rtl/cat_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cat_cmd_tx                                                           |
// | Sends 'A'..'H' / 'a'..'h' commands to bring a remote cat mask in sync.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cat_cmd_tx
  import badge_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic   clk,
  input  wire logic   reset,
  cat_cmd_tx_if.slave bus
);
  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [2:0]          r_idx;
  logic [NUM_CATS-1:0] r_shadow;
  logic [NUM_CATS-1:0] r_tgt;
  logic [NUM_CATS-1:0] r_pend_tgt;
  logic                r_frc;
  logic                r_pend_valid;
  logic                r_pend_frc;
  logic                r_done;
  logic                w_strobe;
  logic                w_need;
  logic                w_byte_start;
  logic                w_fin_done;
  logic                w_byte_done;
  logic                w_uart_busy;
  logic                w_tx;
  logic [7:0]          w_byte;

  assign w_strobe = bus.update | bus.force_all;
  assign w_need   = r_frc | (r_tgt[r_idx] != r_shadow[r_idx]);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_strobe) w_next = ST_SCAN;
      ST_SCAN: begin
        if (w_need)               w_next = ST_SEND;
        else if (r_idx == 3'd7)   w_next = ST_FIN;
      end
      ST_SEND: if (w_byte_done) w_next = (r_idx == 3'd7) ? ST_FIN : ST_SCAN;
      ST_FIN:  w_next = (r_pend_valid || w_strobe) ? ST_SCAN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A strobe landing in FIN is served at once instead of being lost
  always_comb begin
    w_byte_start = (r_state == ST_SCAN) && w_need;
    w_byte       = cmd_byte(r_tgt[r_idx], r_idx);
    w_fin_done   = (r_state == ST_FIN) && !r_pend_valid && !w_strobe;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx        <= '0;
      r_shadow     <= CAT_RESET_MASK;
      r_tgt        <= '0;
      r_frc        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= '0;
      r_pend_frc   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_fin_done;
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_tgt <= bus.target;
            r_frc <= bus.force_all;
            r_idx <= '0;
          end
        end
        ST_SCAN, ST_SEND: begin
          if (r_state == ST_SCAN && !w_need && r_idx != 3'd7)
            r_idx <= r_idx + 3'd1;
          if (r_state == ST_SEND && w_byte_done) begin
            r_shadow[r_idx] <= r_tgt[r_idx];
            if (r_idx != 3'd7) r_idx <= r_idx + 3'd1;
          end
          if (w_strobe) begin
            r_pend_valid <= 1'b1;
            r_pend_tgt   <= bus.target;
            r_pend_frc   <= r_pend_frc | bus.force_all;
          end
        end
        ST_FIN: begin
          r_idx <= '0;
          if (r_pend_valid) begin
            r_tgt        <= r_pend_tgt;
            r_frc        <= r_pend_frc;
            r_pend_valid <= w_strobe;
            r_pend_tgt   <= bus.target;
            r_pend_frc   <= bus.force_all;
          end else if (w_strobe) begin
            r_tgt <= bus.target;
            r_frc <= bus.force_all;
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (w_byte_start),
    .data  (w_byte),
    .tx    (w_tx),
    .busy  (w_uart_busy),
    .done  (w_byte_done)
  );

  assign bus.tx     = w_tx;
  assign bus.busy   = (r_state != ST_IDLE) | w_uart_busy;
  assign bus.done   = r_done;
  assign bus.shadow = r_shadow;
endmodule
`default_nettype wire

// File: tb/tb_cat_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cat_cmd_tx                                                        |
// | Random and directed command batches against a mask-level model.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cat_cmd_tx;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  cat_cmd_tx_if bus();
  cat_cmd_tx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_sh = 8'hFF;
  bit         mon_en = 1'b0;
  int         done_cnt = 0;
  int         edge_cnt = 0;
  logic       tx_prev = 1'b1;
  int         mon_s;
  logic [7:0] mon_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.done === 1'b1) done_cnt++;
    if (bus.tx !== tx_prev) edge_cnt++;
    tx_prev = bus.tx;
  end

  // serial decoder: samples mid-bit
  initial forever begin
    @(negedge clk);
    if (mon_en && bus.tx === 1'b0) begin
      mon_s = cyc;
      repeat (CPB + CPB / 2 - 1) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        mon_b[k] = bus.tx;
        repeat (CPB) @(negedge clk);
      end
      if (mon_en) begin
        check("stop_bit", {31'd0, bus.tx}, 32'd1);
        rx_q.push_back(mon_b);
        st_q.push_back(mon_s);
      end
    end
  end

  // one batch as seen by the receiver: ascending cats, changed or forced only
  function automatic void model_batch(input logic [7:0] tgt, input bit frc);
    for (int i = 0; i < 8; i++) begin
      if (frc || tgt[i] != m_sh[i]) begin
        exp_q.push_back(tgt[i] ? 8'(8'h61 + i) : 8'(8'h41 + i));
        m_sh[i] = tgt[i];
      end
    end
  endfunction

  task automatic strobe(input logic [7:0] tgt, input bit upd, input bit frc, output int scyc);
    @(posedge clk); #1;
    bus.target    = tgt;
    bus.update    = upd;
    bus.force_all = frc;
    scyc          = cyc;
    @(posedge clk); #1;
    bus.update    = 1'b0;
    bus.force_all = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", {31'd0, dcyc >= 0}, 32'd1);
  endtask

  task automatic clear_q();
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  task automatic verify(input string tag, input int base);
    repeat (15) @(negedge clk);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_shadow"}, {24'd0, bus.shadow}, {24'd0, m_sh});
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_dones"}, done_cnt - base, 32'd1);
  endtask

  task automatic run(input string tag, input logic [7:0] tgt, input bit upd, input bit frc,
                     output int scyc, output int dcyc);
    int base;
    clear_q();
    base = done_cnt;
    strobe(tgt, upd, frc, scyc);
    model_batch(tgt, frc);
    wait_done(dcyc);
    verify(tag, base);
  endtask

  initial begin
    int s, d, base, e0, n_ex;
    logic [7:0] t1, pt;
    bit f1, pf, fe, ue;

    bus.target = 8'h00;
    bus.update = 1'b0;
    bus.force_all = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_shadow", {24'd0, bus.shadow}, 32'hFF);
    e0 = edge_cnt;
    repeat (20) @(negedge clk);
    check("idle_edges", edge_cnt - e0, 32'd0);
    mon_en = 1'b1;

    run("fe", 8'hFE, 1'b1, 1'b0, s, d);
    check("fe_start_lat", (st_q.size() > 0) ? st_q[0] - s : -1, 32'd2);

    run("forceff", 8'hFF, 1'b0, 1'b1, s, d);
    for (int i = 1; i < st_q.size(); i++)
      check("force_spacing", st_q[i] - st_q[i-1], 10 * CPB + 1);

    run("5a", 8'h5A, 1'b1, 1'b0, s, d);
    e0 = edge_cnt;
    run("5a_rep", 8'h5A, 1'b1, 1'b0, s, d);
    check("5a_rep_edges", edge_cnt - e0, 32'd0);
    check("5a_rep_lat", d - s, 32'd10);

    // overwrite of the pending slot while a forced batch is running
    clear_q();
    base = done_cnt;
    strobe(8'h3C, 1'b0, 1'b1, s);
    model_batch(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    strobe(8'h00, 1'b1, 1'b0, s);
    repeat (20) @(posedge clk);
    strobe(8'hF0, 1'b1, 1'b0, s);
    model_batch(8'hF0, 1'b0);
    wait_done(d);
    verify("pend", base);

    for (int it = 0; it < 10; it++) begin
      clear_q();
      base = done_cnt;
      t1 = 8'($urandom);
      f1 = ($urandom % 4) == 0;
      strobe(t1, !f1 || ($urandom % 2 == 1), f1, s);
      n_ex = $urandom % 3;
      pt = 8'h00;
      pf = 1'b0;
      for (int j = 0; j < n_ex; j++) begin
        repeat ($urandom_range(0, 1)) @(posedge clk);
        fe = ($urandom % 3) == 0;
        ue = !fe || ($urandom % 2 == 1);
        pt = 8'($urandom);
        pf = pf | fe;
        strobe(pt, ue, fe, d);
      end
      model_batch(t1, f1);
      if (n_ex > 0) model_batch(pt, pf);
      wait_done(d);
      verify("rand", base);
    end

    run("all_off", 8'h00, 1'b0, 1'b1, s, d);

    // abort a frame in its start bit
    mon_en = 1'b0;
    strobe(8'hFF, 1'b1, 1'b0, s);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_tx_before", {31'd0, bus.tx}, 32'd0);
    @(negedge clk);
    check("abort_tx", {31'd0, bus.tx}, 32'd1);
    check("abort_shadow", {24'd0, bus.shadow}, 32'hFF);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    e0 = edge_cnt;
    repeat (60) @(negedge clk);
    check("abort_quiet", edge_cnt - e0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
